dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed data memory.
- Requester 0 is the CPU load/store unit; requester 1 is the debug/DMA port.
- Accepts one request at a time, sequences it onto the single memory port, and returns a registered response with read data or an error flag.
- Round-robin fairness; range/width checking so illegal accesses never reach the memory.

Parameters:
ADDR_W, 10, byte address width (matches `DATA_MEM_WIDTH)
DATA_W, 64, data width (matches `DATA_WIDTH)
MEM_BYTES, 1024, addressable bytes; limit for range check

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  2  per-requester request valid; bit i = requester i
req_ready  out  2  per-requester accept; one-hot or zero
req_we  in  2  per-requester write enable (0 = read)
req_width  in  2x3  per-requester width code: 000 byte, 001 half, 010 word, 011 dword
req_addr  in  2xADDR_W  per-requester byte address
req_wdata  in  2xDATA_W  per-requester write data
rsp_valid  out  2  one-cycle response pulse, bit i = requester i
rsp_err  out  1  qualifies rsp_valid; 1 = access rejected
rsp_rdata  out  DATA_W  read data, zero-extended; 0 for writes and errors
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_width  out  3  memory width code
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- FSM has two states, IDLE and ACCESS. Reset state is IDLE.
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - mem_re = 0, mem_we = 0; all mem_* buses = 0.
  - RR pointer rr_last = 1, so requester 0 wins the first tie.
- IDLE, cycle N:
  - If any req_valid bit is set, pick the winner. On a tie, the requester other than rr_last wins.
  - req_ready[winner] = 1 combinationally in cycle N. This is the handshake.
  - Latch we/width/addr/wdata/id of the winner at the clock edge, update rr_last = winner, and go to ACCESS.
  - With no valid request, stay in IDLE; req_ready = 0.
- Legality check at latch time:
  - size = 1 << width[1:0].
  - Illegal if width > 3, or addr + size > MEM_BYTES. The sum is computed at ADDR_W+1 bits, with no wrap.
  - The result is latched as an err flag.
- ACCESS, cycle N+1:
  - If legal: mem_re = !we and mem_we = we; mem_width/addr/wdata driven from the latch. The memory write commits at the end of N+1.
  - If illegal: mem_re = mem_we = 0.
  - mem_* outputs are 0 in every cycle outside ACCESS.
  - At the edge: register rsp_rdata = (legal read) ? mem_rdata : 0, rsp_err = err, and rsp_valid[id] = 1. Then return to IDLE.
- Cycle N+2:
  - rsp_valid pulses for exactly this one cycle.
  - The FSM is in IDLE and may accept the next request in the same cycle.
  - Throughput is 1 access per 2 cycles. Latency from accept to response is 2 cycles.
- Requesters must hold req_* stable while req_valid && !req_ready. Dropping req_valid before ready is allowed: the request is withdrawn.
- req_ready is never asserted in ACCESS.
- The accept cycle is fully combinational from req_valid to req_ready. There are no other combinational paths from request inputs to outputs.
- When rsp_valid is 0, rsp_err and rsp_rdata hold their last values; verification ignores them.
- Reset mid-operation:
  - Synchronous rst in ACCESS aborts the access: mem_we is forced to 0 that cycle and no response is issued.
  - All state returns to reset values.

Decomposition:
- Shared package/include (common.vh): width codes BYTE/HALF/WORD/DWORD, FSM state encodings, requester ID constants.
- One sub-module, dmem_rr_pick: 2-way round-robin picker. Inputs: valid[1:0], rr_last. Outputs: grant one-hot and winner id.
- Legality check and FSM stay in the top module.

Test Plan:
1. Requester 0 writes dword 0x1122334455667788 at addr 0x10, then reads it back.
   - Write: accept at N; mem_we high at N+1 only; rsp_valid[0] at N+2 with err=0, rdata=0.
   - Read: rdata=0x1122334455667788.
2. Both requesters request every cycle.
   - Grants alternate 0,1,0,1; each rsp_valid bit follows its own grant by 2 cycles.
   - Neither side starves across 8 requests.
3. Read with width=001 at addr 0x3FF (the last byte).
   - rsp_err=1, rdata=0; mem_re/mem_we stay 0 throughout.
   - A byte read at 0x3FF is legal.
   - width=3'b100 at addr 0 gives rsp_err=1.
4. Byte write 0xAB to addr 5, then word read at addr 4.
   - rdata = 0x000000000000AB00 (assuming bytes 4..7 were zero).
5. Requester 1 drops req_valid while requester 0 is in ACCESS.
   - No grant, no response for requester 1.
   - A later request from requester 1 is served normally.
6. Assert rst during the ACCESS cycle of a write of 0xFF to addr 0x20.
   - No rsp_valid pulse; a subsequent read of 0x20 returns 0; all outputs return to 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared width codes, FSM states and requester ids for dmem_arbiter
package dmem_arbiter_pkg;

    localparam logic [2:0] WIDTH_BYTE  = 3'b000;
    localparam logic [2:0] WIDTH_HALF  = 3'b001;
    localparam logic [2:0] WIDTH_WORD  = 3'b010;
    localparam logic [2:0] WIDTH_DWORD = 3'b011;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Byte-lane mask used to zero-extend narrow reads.
    function automatic logic [63:0] width_mask(input logic [2:0] width);
        logic [63:0] mask;
        case (width[1:0])
            WIDTH_BYTE[1:0]: mask = 64'h0000_0000_0000_00ff;
            WIDTH_HALF[1:0]: mask = 64'h0000_0000_0000_ffff;
            WIDTH_WORD[1:0]: mask = 64'h0000_0000_ffff_ffff;
            default:         mask = 64'hffff_ffff_ffff_ffff;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - 2-way round-robin picker: one-hot grant plus winner id
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = REQ_CPU;
        grant  = 2'b00;
        case (valid)
            2'b01:   winner = REQ_CPU;
            2'b10:   winner = REQ_DBG;
            2'b11:   winner = ~rr_last;
            default: winner = REQ_CPU;
        endcase
        if (valid != 2'b00) begin
            grant = (winner == REQ_DBG) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter and sequencer for the data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][2:0]        req_width,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic                   rsp_err,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [2:0]             mem_width,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    state_t state, state_nx;
    logic   rr_last;
    logic   accept;

    logic [1:0] grant;
    logic       win_id;

    logic              lat_we;
    logic [2:0]        lat_width;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_id;
    logic              lat_err;

    logic [2:0]        win_width;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W:0]   acc_end;
    logic              win_illegal;

    dmem_rr_pick u_pick (
        .valid   (req_valid),
        .rr_last (rr_last),
        .grant   (grant),
        .winner  (win_id)
    );

    // End address is one bit wider than the address so an overrun cannot wrap to a legal value.
    assign win_width   = req_width[win_id];
    assign win_addr    = req_addr[win_id];
    assign acc_end     = {1'b0, win_addr} + ((ADDR_W+1)'(1) << win_width[1:0]);
    assign win_illegal = win_width[2] || (acc_end > (ADDR_W+1)'(MEM_BYTES));

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        req_ready = 2'b00;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_width = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                if ((req_valid != 2'b00) && !rst) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_nx  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_nx = ST_IDLE;
                // Reset in this cycle aborts the access before the write can commit.
                if (!lat_err && !rst) begin
                    mem_re    = !lat_we;
                    mem_we    = lat_we;
                    mem_width = lat_width;
                    mem_addr  = lat_addr;
                    mem_wdata = lat_wdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_last   <= REQ_DBG;
            lat_we    <= 1'b0;
            lat_width <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_id    <= REQ_CPU;
            lat_err   <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 2'b00;
            if (accept) begin
                lat_we    <= req_we[win_id];
                lat_width <= win_width;
                lat_addr  <= win_addr;
                lat_wdata <= req_wdata[win_id];
                lat_id    <= win_id;
                lat_err   <= win_illegal;
                rr_last   <= win_id;
            end
            if (state == ST_ACCESS) begin
                rsp_valid <= (lat_id == REQ_DBG) ? 2'b10 : 2'b01;
                rsp_err   <= lat_err;
                rsp_rdata <= (!lat_err && !lat_we)
                             ? (mem_rdata & DATA_W'(width_mask(lat_width)))
                             : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a byte memory model
module tb_dmem_arbiter;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 64;
    localparam int MEM_BYTES = 1024;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0][2:0]        req_width;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             rsp_valid;
    logic                   rsp_err;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   mem_re;
    logic                   mem_we;
    logic [2:0]             mem_width;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    logic [7:0] mem [0:MEM_BYTES-1];

    int checks   = 0;
    int failures = 0;
    int gnt0     = 0;
    int gnt1     = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_width (req_width),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_width (mem_width),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Little-endian byte memory: combinational read, zero-extended, write at clock edge.
    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            if ((k < (1 << mem_width[1:0])) && (int'(mem_addr) + k < MEM_BYTES)) begin
                mem_rdata[8*k +: 8] = mem[int'(mem_addr) + k];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                if ((k < (1 << mem_width[1:0])) && (int'(mem_addr) + k < MEM_BYTES)) begin
                    mem[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept cycle, access cycle, response cycle.
    task automatic do_req(input string tag, input int id, input logic we, input logic [2:0] width,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic exp_err, input logic [DATA_W-1:0] exp_rdata);
        req_valid     = 2'b00;
        req_valid[id] = 1'b1;
        req_we[id]    = we;
        req_width[id] = width;
        req_addr[id]  = addr;
        req_wdata[id] = wdata;
        #1;
        chk({tag, ".ready"}, 64'(req_ready), (id == 1) ? 64'd2 : 64'd1);
        tick();
        req_valid = 2'b00;
        #1;
        chk({tag, ".ready_access"}, 64'(req_ready), 64'd0);
        chk({tag, ".mem_we"}, 64'(mem_we), 64'(we && !exp_err));
        chk({tag, ".mem_re"}, 64'(mem_re), 64'(!we && !exp_err));
        if (!exp_err) begin
            chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(addr));
            chk({tag, ".mem_width"}, 64'(mem_width), 64'(width));
        end
        tick();
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), (id == 1) ? 64'd2 : 64'd1);
        chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
        chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".mem_idle"}, 64'({mem_re, mem_we}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_width = '0;
        req_addr  = '0;
        req_wdata = '0;
        tick();
        tick();
        chk("reset.req_ready", 64'(req_ready), 64'd0);
        chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset.rsp_err", 64'(rsp_err), 64'd0);
        chk("reset.rsp_rdata", rsp_rdata, 64'd0);
        chk("reset.mem_ctl", 64'({mem_re, mem_we}), 64'd0);
        chk("reset.mem_bus", 64'(mem_addr) | 64'(mem_width) | mem_wdata, 64'd0);
        rst = 1'b0;

        // Dword write then read back.
        do_req("t1_wr", 0, 1'b1, 3'b011, 10'h010, 64'h1122334455667788, 1'b0, 64'd0);
        do_req("t1_rd", 0, 1'b0, 3'b011, 10'h010, 64'd0, 1'b0, 64'h1122334455667788);

        // Range and width checks.
        do_req("t3_half_last", 0, 1'b0, 3'b001, 10'h3ff, 64'd0, 1'b1, 64'd0);
        do_req("t3_byte_last", 0, 1'b0, 3'b000, 10'h3ff, 64'd0, 1'b0, 64'd0);
        do_req("t3_bad_width", 0, 1'b0, 3'b100, 10'h000, 64'd0, 1'b1, 64'd0);

        // Byte write then word read covering it.
        do_req("t4_wr", 0, 1'b1, 3'b000, 10'h005, 64'h00000000000000ab, 1'b0, 64'd0);
        do_req("t4_rd", 0, 1'b0, 3'b010, 10'h004, 64'd0, 1'b0, 64'h000000000000ab00);

        // Requester 1 withdraws while requester 0 is in ACCESS.
        req_valid    = 2'b01;
        req_we       = 2'b00;
        req_width[0] = 3'b000;
        req_addr[0]  = 10'h005;
        #1;
        chk("t5.ready0", 64'(req_ready), 64'd1);
        tick();
        req_valid    = 2'b10;
        req_width[1] = 3'b011;
        req_addr[1]  = 10'h010;
        #1;
        chk("t5.ready_access", 64'(req_ready), 64'd0);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t5.ready_withdrawn", 64'(req_ready), 64'd0);
        chk("t5.rsp0", 64'(rsp_valid), 64'd1);
        chk("t5.rdata0", rsp_rdata, 64'h00000000000000ab);
        tick();
        chk("t5.no_rsp1", 64'(rsp_valid), 64'd0);
        do_req("t5_later", 1, 1'b0, 3'b011, 10'h010, 64'd0, 1'b0, 64'h1122334455667788);

        // Both requesters valid every cycle: grants alternate, starting with 0.
        req_valid    = 2'b11;
        req_we       = 2'b00;
        req_width[0] = 3'b011;
        req_addr[0]  = 10'h010;
        req_width[1] = 3'b010;
        req_addr[1]  = 10'h004;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t2.grant%0d", i), 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            if (req_ready == 2'b01) gnt0++;
            if (req_ready == 2'b10) gnt1++;
            if (i > 0) begin
                chk($sformatf("t2.rsp%0d", i - 1), 64'(rsp_valid), (i % 2 == 1) ? 64'd1 : 64'd2);
                chk($sformatf("t2.rdata%0d", i - 1), rsp_rdata,
                    (i % 2 == 1) ? 64'h1122334455667788 : 64'h000000000000ab00);
            end
            tick();
            chk($sformatf("t2.access_ready%0d", i), 64'(req_ready), 64'd0);
            chk($sformatf("t2.access_rsp%0d", i), 64'(rsp_valid), 64'd0);
            tick();
        end
        req_valid = 2'b00;
        #1;
        chk("t2.rsp7", 64'(rsp_valid), 64'd2);
        chk("t2.rdata7", rsp_rdata, 64'h000000000000ab00);
        chk("t2.count0", 64'(gnt0), 64'd4);
        chk("t2.count1", 64'(gnt1), 64'd4);
        tick();

        // Reset during the ACCESS cycle of a write aborts it.
        req_valid    = 2'b01;
        req_we[0]    = 1'b1;
        req_width[0] = 3'b000;
        req_addr[0]  = 10'h020;
        req_wdata[0] = 64'h00000000000000ff;
        #1;
        chk("t6.ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        rst       = 1'b1;
        #1;
        chk("t6.mem_we_forced", 64'(mem_we), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6.no_rsp", 64'(rsp_valid), 64'd0);
        chk("t6.outputs_zero", 64'({req_ready, rsp_err, mem_re, mem_we}) | rsp_rdata | 64'(mem_addr), 64'd0);
        tick();
        chk("t6.no_rsp_late", 64'(rsp_valid), 64'd0);
        do_req("t6_rd", 0, 1'b0, 3'b000, 10'h020, 64'd0, 1'b0, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
